// File: rtl/fft_pkg.sv
// Shared types and address helpers for the radix-2 constant-geometry FFT address units.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, GEN, WAIT} state_t;

  // Rotate {j,b} left by s within an n-bit address.
  function automatic logic [31:0] rotl_addr(input logic [31:0] j, input logic b,
                                            input int unsigned s, input int unsigned n);
    logic [31:0] v;
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    v    = ((j << 1) | {31'd0, b}) & mask;
    return ((v << s) | (v >> (n - s))) & mask;
  endfunction

  function automatic logic [31:0] tw_index(input logic [31:0] j, input int unsigned s,
                                           input int unsigned m);
    return (j << (m - s)) & ((32'd1 << m) - 32'd1);
  endfunction

endpackage

// File: rtl/fft_agu_addr_core.sv
// Combinational butterfly/twiddle address mapping from stage and butterfly index.
module fft_agu_addr_core
  import fft_pkg::*;
#(
  parameter int LOG2N = 10,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    i_s,
  input  logic [LOG2N-2:0] i_j,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [LOG2N-2:0] o_tw_addr
);

  localparam int M = LOG2N - 1;

  assign o_addr_a  = LOG2N'(rotl_addr(32'(i_j), 1'b0, 32'(i_s), LOG2N));
  assign o_addr_b  = LOG2N'(rotl_addr(32'(i_j), 1'b1, 32'(i_s), LOG2N));
  assign o_tw_addr = M'(tw_index(32'(i_j), 32'(i_s), M));

endmodule

// File: rtl/fft_agu_param.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT with drain gap, stall and handshake.
// state | meaning
// IDLE  | waiting for start_i
// GEN   | issuing one butterfly per unstalled cycle
// WAIT  | pipeline drain gap between stages
module fft_agu_param
  import fft_pkg::*;
#(
  parameter int LOG2N       = 10,
  parameter int WAIT_CYCLES = 4,
  parameter int SW          = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic             memsel_o,
  output logic [SW-1:0]    stage_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int M  = LOG2N - 1;
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] W_LAST = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  state_t        r_state, w_state_nxt;
  logic [M-1:0]  r_j, w_j_nxt;
  logic [SW-1:0] r_s, w_s_nxt;
  logic [WW-1:0] r_w, w_w_nxt;

  logic             w_fire, w_j_end, w_s_end;
  logic [LOG2N-1:0] w_addr_a, w_addr_b;
  logic [M-1:0]     w_tw;

  logic             r_busy, r_valid, r_memsel, r_last, r_done;
  logic [LOG2N-1:0] r_addr_a, r_addr_b;
  logic [M-1:0]     r_tw;
  logic [SW-1:0]    r_stage;

  assign w_fire  = (r_state == GEN) && !stall_i;
  assign w_j_end = &r_j;
  assign w_s_end = (r_s == S_LAST);

  fft_agu_addr_core #(.LOG2N(LOG2N), .SW(SW)) u_addr_core (
    .i_s      (r_s),
    .i_j      (r_j),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_tw_addr(w_tw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_j     <= '0;
      r_s     <= '0;
      r_w     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_s     <= w_s_nxt;
      r_w     <= w_w_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_s_nxt     = r_s;
    w_w_nxt     = r_w;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = GEN;
          w_j_nxt     = '0;
          w_s_nxt     = '0;
          w_w_nxt     = '0;
        end
      end
      GEN: begin
        if (!stall_i) begin
          if (!w_j_end) begin
            w_j_nxt = r_j + M'(1);
          end else if (w_s_end) begin
            w_state_nxt = IDLE;
            w_j_nxt     = '0;
            w_s_nxt     = '0;
          end else if (WAIT_CYCLES == 0) begin
            w_j_nxt = '0;
            w_s_nxt = r_s + SW'(1);
          end else begin
            w_state_nxt = WAIT;
            w_w_nxt     = '0;
          end
        end
      end
      WAIT: begin
        if (r_w == W_LAST) begin
          w_state_nxt = GEN;
          w_j_nxt     = '0;
          w_s_nxt     = r_s + SW'(1);
          w_w_nxt     = '0;
        end else begin
          w_w_nxt = r_w + WW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Busy covers the cycle after the final butterfly is issued, so last_o sees busy_o high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_tw     <= '0;
      r_memsel <= 1'b0;
      r_stage  <= '0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy   <= (r_state != IDLE) || (w_state_nxt != IDLE);
      r_valid  <= w_fire;
      r_addr_a <= w_fire ? w_addr_a : '0;
      r_addr_b <= w_fire ? w_addr_b : '0;
      r_tw     <= w_fire ? w_tw : '0;
      r_memsel <= r_s[0];
      r_stage  <= r_s;
      r_last   <= w_fire && w_j_end && w_s_end;
      r_done   <= r_last;
    end
  end

  assign busy_o    = r_busy;
  assign valid_o   = r_valid;
  assign addr_a_o  = r_addr_a;
  assign addr_b_o  = r_addr_b;
  assign tw_addr_o = r_tw;
  assign memsel_o  = r_memsel;
  assign stage_o   = r_stage;
  assign last_o    = r_last;
  assign done_o    = r_done;

endmodule

// File: tb/tb_fft_agu_param.sv
// Bench for fft_agu_param: three configurations share stimulus, one is observed per test.
module tb_fft_agu_param;

  localparam int NC = 16384;

  typedef struct {
    int valid; int a; int b; int tw; int st; int mem; int last; int done; int busy;
  } obs_t;

  typedef struct {
    int cyc; int valid; int a; int b; int tw; int st; int last; int done;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_i, stall_i;

  logic       p_busy, p_valid, p_mem, p_last, p_done;
  logic [2:0] p_a, p_b;
  logic [1:0] p_tw, p_st;
  logic       q_busy, q_valid, q_mem, q_last, q_done;
  logic [2:0] q_a, q_b;
  logic [1:0] q_tw, q_st;
  logic       r_busy, r_valid, r_mem, r_last, r_done;
  logic [9:0] r_a, r_b;
  logic [8:0] r_tw;
  logic [3:0] r_st;

  fft_agu_param #(.LOG2N(3), .WAIT_CYCLES(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i), .busy_o(p_busy),
    .valid_o(p_valid), .addr_a_o(p_a), .addr_b_o(p_b), .tw_addr_o(p_tw), .memsel_o(p_mem),
    .stage_o(p_st), .last_o(p_last), .done_o(p_done));

  fft_agu_param #(.LOG2N(3), .WAIT_CYCLES(0)) dut_q (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i), .busy_o(q_busy),
    .valid_o(q_valid), .addr_a_o(q_a), .addr_b_o(q_b), .tw_addr_o(q_tw), .memsel_o(q_mem),
    .stage_o(q_st), .last_o(q_last), .done_o(q_done));

  fft_agu_param #(.LOG2N(10), .WAIT_CYCLES(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i), .busy_o(r_busy),
    .valid_o(r_valid), .addr_a_o(r_a), .addr_b_o(r_b), .tw_addr_o(r_tw), .memsel_o(r_mem),
    .stage_o(r_st), .last_o(r_last), .done_o(r_done));

  int   sel;
  obs_t cur;
  always_comb begin
    cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    case (sel)
      0: cur = '{int'(p_valid), int'(32'(p_a)), int'(32'(p_b)), int'(32'(p_tw)), int'(32'(p_st)),
                 int'(p_mem), int'(p_last), int'(p_done), int'(p_busy)};
      1: cur = '{int'(q_valid), int'(32'(q_a)), int'(32'(q_b)), int'(32'(q_tw)), int'(32'(q_st)),
                 int'(q_mem), int'(q_last), int'(q_done), int'(q_busy)};
      default: cur = '{int'(r_valid), int'(32'(r_a)), int'(32'(r_b)), int'(32'(r_tw)), int'(32'(r_st)),
                       int'(r_mem), int'(r_last), int'(r_done), int'(r_busy)};
    endcase
  end

  obs_t exp_c[NC];
  obs_t got[NC];
  bit   in_start[NC];
  bit   in_stall[NC];
  bit   in_rst[NC];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int c, input int g, input int e);
    n_tests++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, g, e);
    end
  endtask

  // Address bit i of {j,b} moves to bit (i+s) mod L.
  function automatic int ref_rot(input int v, input int s, input int l);
    int r;
    r = 0;
    for (int i = 0; i < l; i++)
      if (v[i]) r = r | (1 << ((i + s) % l));
    return r;
  endfunction

  function automatic void clear_all();
    for (int c = 0; c < NC; c++) begin
      exp_c[c] = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
      got[c]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      in_start[c] = 1'b0;
      in_stall[c] = 1'b0;
      in_rst[c]   = 1'b0;
    end
  endfunction

  // Butterfly k is issued one cycle after butterfly k-1 (plus the drain gap at a stage
  // boundary), pushed back by every stalled candidate cycle; its outputs appear one cycle later.
  function automatic int add_run(input int c0, input int l, input int w, input int abort);
    int n2, iss, oc, s, j, m, lastc;
    n2 = 1 << (l - 1);
    m = l - 1;
    iss = c0;
    lastc = c0;
    for (int k = 0; k < l * n2; k++) begin
      s = k / n2;
      j = k % n2;
      iss = iss + 1 + ((k != 0 && j == 0) ? w : 0);
      while (iss < NC - 4 && in_stall[iss]) iss++;
      oc = iss + 1;
      lastc = oc;
      if (oc <= abort) begin
        exp_c[oc].valid = 1;
        exp_c[oc].a = ref_rot(2 * j, s, l);
        exp_c[oc].b = ref_rot(2 * j + 1, s, l);
        exp_c[oc].tw = (j * (1 << (m - s))) % (1 << m);
        exp_c[oc].st = s;
        exp_c[oc].last = (k == l * n2 - 1) ? 1 : 0;
      end
    end
    for (int c = c0 + 1; c <= lastc; c++)
      if (c <= abort) exp_c[c].busy = 1;
    if (lastc + 1 <= abort) exp_c[lastc + 1].done = 1;
    return lastc;
  endfunction

  task automatic run_sim(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < ncyc; c++) begin
      got[c]  = cur;
      rst_n   = !in_rst[c];
      start_i = in_start[c];
      stall_i = in_stall[c];
      @(negedge clk);
    end
    start_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic compare_all(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      check({tag, ".valid"}, c, got[c].valid, exp_c[c].valid);
      check({tag, ".addr_a"}, c, got[c].a, exp_c[c].a);
      check({tag, ".addr_b"}, c, got[c].b, exp_c[c].b);
      check({tag, ".tw"}, c, got[c].tw, exp_c[c].tw);
      check({tag, ".last"}, c, got[c].last, exp_c[c].last);
      check({tag, ".done"}, c, got[c].done, exp_c[c].done);
      check({tag, ".busy"}, c, got[c].busy, exp_c[c].busy);
      if (exp_c[c].st >= 0) begin
        check({tag, ".stage"}, c, got[c].st, exp_c[c].st);
        check({tag, ".memsel"}, c, got[c].mem, exp_c[c].st % 2);
      end
    end
  endtask

  vec_t tbl[$];
  int   lc, lc2, ncyc, cnt, vi;
  int   seq_a[$];
  int   seq_b[$];

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stall_i = 1'b0; sel = 0;

    // L=3, W=2 nominal run against the known address table
    tbl = '{
      '{0, 0, 0, 0, 0, 0, 0, 0},  '{1, 0, 0, 0, 0, 0, 0, 0},
      '{2, 1, 0, 1, 0, 0, 0, 0},  '{3, 1, 2, 3, 0, 0, 0, 0},
      '{4, 1, 4, 5, 0, 0, 0, 0},  '{5, 1, 6, 7, 0, 0, 0, 0},
      '{6, 0, 0, 0, 0, 0, 0, 0},  '{7, 0, 0, 0, 0, 0, 0, 0},
      '{8, 1, 0, 2, 0, 1, 0, 0},  '{9, 1, 4, 6, 2, 1, 0, 0},
      '{10, 1, 1, 3, 0, 1, 0, 0}, '{11, 1, 5, 7, 2, 1, 0, 0},
      '{12, 0, 0, 0, 0, 0, 0, 0}, '{13, 0, 0, 0, 0, 0, 0, 0},
      '{14, 1, 0, 4, 0, 2, 0, 0}, '{15, 1, 1, 5, 1, 2, 0, 0},
      '{16, 1, 2, 6, 2, 2, 0, 0}, '{17, 1, 3, 7, 3, 2, 1, 0},
      '{18, 0, 0, 0, 0, 0, 0, 1}, '{19, 0, 0, 0, 0, 0, 0, 0}};
    sel = 0;
    clear_all();
    in_start[0] = 1'b1;
    lc = add_run(0, 3, 2, NC);
    run_sim(24);
    compare_all("nom32", 24);
    for (int i = 0; i < tbl.size(); i++) begin
      check("tbl.valid", tbl[i].cyc, got[tbl[i].cyc].valid, tbl[i].valid);
      check("tbl.addr_a", tbl[i].cyc, got[tbl[i].cyc].a, tbl[i].a);
      check("tbl.addr_b", tbl[i].cyc, got[tbl[i].cyc].b, tbl[i].b);
      check("tbl.tw", tbl[i].cyc, got[tbl[i].cyc].tw, tbl[i].tw);
      check("tbl.last", tbl[i].cyc, got[tbl[i].cyc].last, tbl[i].last);
      check("tbl.done", tbl[i].cyc, got[tbl[i].cyc].done, tbl[i].done);
      if (tbl[i].valid == 1) begin
        check("tbl.stage", tbl[i].cyc, got[tbl[i].cyc].st, tbl[i].st);
        check("tbl.memsel", tbl[i].cyc, got[tbl[i].cyc].mem, tbl[i].st % 2);
      end
    end
    check("rst.busy", 0, got[0].busy, 0);
    check("busy.c1", 1, got[1].busy, 1);
    check("busy.c17", 17, got[17].busy, 1);
    check("busy.c18", 18, got[18].busy, 0);

    // Back-to-back stages
    sel = 1;
    clear_all();
    in_start[0] = 1'b1;
    lc = add_run(0, 3, 0, NC);
    run_sim(20);
    compare_all("w0", 20);
    check("w0.pre_valid", 1, got[1].valid, 0);
    for (int c = 2; c <= 13; c++) check("w0.consec", c, got[c].valid, 1);
    check("w0.post_valid", 14, got[14].valid, 0);
    check("w0.done", 14, got[14].done, 1);

    // Stall in stage 0 plus an ignored start mid-run
    sel = 0;
    clear_all();
    in_start[0] = 1'b1;
    in_stall[3] = 1'b1;
    in_stall[4] = 1'b1;
    in_start[7] = 1'b1;
    lc = add_run(0, 3, 2, NC);
    run_sim(26);
    compare_all("stall", 26);
    check("stall.v4", 4, got[4].valid, 0);
    check("stall.v5", 5, got[5].valid, 0);
    check("stall.done", 20, got[20].done, 1);
    seq_a.delete();
    seq_b.delete();
    for (int c = 0; c < 26; c++)
      if (got[c].valid == 1) begin
        seq_a.push_back(got[c].a);
        seq_b.push_back(got[c].b);
      end
    check("stall.count", 0, seq_a.size(), 12);
    vi = 0;
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].valid == 1) begin
        if (vi < seq_a.size()) begin
          check("stall.seq_a", vi, seq_a[vi], tbl[i].a);
          check("stall.seq_b", vi, seq_b[vi], tbl[i].b);
        end
        vi++;
      end

    // Reset mid-run (start held high with it), restart at cycle 12
    sel = 0;
    clear_all();
    in_start[0] = 1'b1;
    in_rst[8] = 1'b1;
    in_start[8] = 1'b1;
    in_start[12] = 1'b1;
    lc = add_run(0, 3, 2, 8);
    lc = add_run(12, 3, 2, NC);
    run_sim(36);
    compare_all("reset", 36);
    check("reset.busy9", 9, got[9].busy, 0);
    check("reset.valid9", 9, got[9].valid, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) cnt += got[c].done;
    check("reset.no_done", 0, cnt, 0);
    check("reset.last29", 29, got[29].last, 1);
    check("reset.done30", 30, got[30].done, 1);

    // 1024-point nominal run
    sel = 2;
    clear_all();
    in_start[0] = 1'b1;
    lc = add_run(0, 10, 4, NC);
    run_sim(5165);
    compare_all("n1024", 5165);
    cnt = 0;
    for (int c = 0; c < 5165; c++) cnt += got[c].valid;
    check("n1024.valids", 0, cnt, 5120);
    check("n1024.last", 5157, got[5157].last, 1);
    check("n1024.done", 5158, got[5158].done, 1);
    check("n1024.s9j5_a", 4651, got[4651].a, 5);
    check("n1024.s9j5_b", 4651, got[4651].b, 517);
    check("n1024.s9j5_tw", 4651, got[4651].tw, 5);

    // Random stalls, ignored mid-run starts, restart in the done cycle
    for (int r = 0; r < 9; r++) begin
      sel = (r == 8) ? 2 : r % 2;
      clear_all();
      for (int c = 0; c < NC; c++)
        in_stall[c] = (sel == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
      in_start[0] = 1'b1;
      lc = add_run(0, (sel == 2) ? 10 : 3, (sel == 0) ? 2 : ((sel == 1) ? 0 : 4), NC);
      for (int c = 1; c < lc; c++)
        if ($urandom_range(0, 7) == 0) in_start[c] = 1'b1;
      ncyc = lc + 4;
      if (sel != 2) begin
        in_start[lc + 1] = 1'b1;
        lc2 = add_run(lc + 1, 3, (sel == 0) ? 2 : 0, NC);
        ncyc = lc2 + 4;
      end
      run_sim(ncyc);
      compare_all("rand", ncyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_agu_param.md
Name: fft_agu_param

Overview:
- Parametrised address generation unit for an in-place, radix-2, constant-geometry FFT of N = 2^LOG2N points.
- Per stage it emits one butterfly per cycle: two data-memory addresses, one twiddle ROM address and the ping-pong bank select.
- Sits between the FFT control sequencer (start/done) and the dual-port sample RAMs plus twiddle ROM.
- Adds to the fixed 1024-point unit: configurable size, configurable inter-stage drain gap, stall input, and busy/valid/last/done handshake.

Parameters:
- LOG2N, 10, log2 of FFT length; legal range 2..12; M = LOG2N-1 is the butterfly-index width.
- WAIT_CYCLES, 4, idle cycles between stages for butterfly pipeline drain; 0 means stages run back-to-back.
- SW, $clog2(LOG2N), width of the stage index.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- start_i  in  1  start a transform; sampled only in IDLE.
- stall_i  in  1  hold the butterfly counter in GEN; ignored in IDLE and WAIT.
- busy_o  out  1  transform in progress.
- valid_o  out  1  address outputs are valid this cycle.
- addr_a_o  out  LOG2N  upper-input butterfly address.
- addr_b_o  out  LOG2N  lower-input butterfly address.
- tw_addr_o  out  M  twiddle ROM address (N/2 entries).
- memsel_o  out  1  read bank select = stage[0].
- stage_o  out  SW  current stage 0..LOG2N-1.
- last_o  out  1  final butterfly of final stage (coincident with valid_o).
- done_o  out  1  one-cycle pulse when the transform completes.

Behaviour:
- FSM states:
  - IDLE: start_i=1 -> GEN with j=0, s=0.
  - GEN: j increments unless stall_i. At j=N/2-1 and not stalled: if s=LOG2N-1 -> IDLE; else if WAIT_CYCLES=0 -> GEN with s+1, j=0; else -> WAIT with wait counter w=0.
  - WAIT: w increments; at w=WAIT_CYCLES-1 -> GEN with s+1, j=0.
- Address generation (combinational from s and j, then registered once):
  - addr_a = rotl({j,1'b0}, s); addr_b = rotl({j,1'b1}, s); rotation is over LOG2N bits.
  - tw_addr = (j << (M-s)) mod 2^M. Stage 0 always gives 0; the last stage gives j.
- Output registers:
  - All outputs are registered.
  - valid_o=1 only for GEN cycles with stall_i=0, appearing on the following cycle.
  - When valid_o=0, addr_a_o, addr_b_o and tw_addr_o are 0; memsel_o and stage_o still track s.
- Latency (start sampled at cycle 0, no stalls):
  - First valid at cycle 2.
  - Each stage gives N/2 consecutive valids; stages are separated by WAIT_CYCLES invalid cycles.
  - last_o is set at cycle 1 + LOG2N*N/2 + (LOG2N-1)*WAIT_CYCLES; done_o pulses the next cycle.
- busy_o: 1 from cycle 1 through the last_o cycle; 0 in the done_o cycle.
- Stall: each stalled GEN cycle delays all later events by one cycle and inserts one valid_o=0 cycle. A stall on j=N/2-1 holds the stage transition.
- start_i while busy is ignored. start_i in the done_o cycle (FSM already in IDLE) is accepted.
- Reset:
  - All outputs are 0 and the FSM is in IDLE; counters j, s, w are cleared.
  - Reset asserted mid-transform aborts it: no done_o, outputs are 0 on the next cycle.
- Reset has priority over start_i.

Decomposition:
- Package fft_pkg holds:
  - the state enum {IDLE, GEN, WAIT};
  - a function rotl_addr(j, b, s, LOG2N);
  - a function tw_index(j, s, M).
- One sub-module, fft_agu_addr_core: purely combinational {s, j} -> {addr_a, addr_b, tw_addr}. It is reusable by the DIF variant.
- FSM and counters live in the top module.

Test Plan:
- LOG2N=3, WAIT_CYCLES=2, start at cycle 0:
  - stage 0 (A,B,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0) on cycles 2..5;
  - stage 1 = (0,2,0),(4,6,2),(1,3,0),(5,7,2);
  - stage 2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3);
  - last_o at 17, done_o at 18.
- Same configuration: valid_o=0 on cycles 6-7 and 12-13; memsel_o=1 during stage 1; stage_o steps 0,1,2.
- LOG2N=10, WAIT_CYCLES=4: exactly 5120 valids; last_o at cycle 5157; done_o at 5158. Check stage 9, j=5 -> A=5, B=517, tw=5.
- LOG2N=3, WAIT_CYCLES=0: 12 consecutive valids on cycles 2..13, done_o at 14.
- stall_i=1 for cycles 3-4 in stage 0: valid_o low on cycles 4-5, no address skipped or repeated, done_o delayed by 2 cycles. start_i pulsed mid-run has no effect.
- rst_n=0 at cycle 8, start again at cycle 12: no done_o from the first run; second run completes with nominal timing relative to cycle 12.
